psram_bram_responder: RTL and testbench

Block-RAM-backed responder for the PSRAM controller user-side command port (cmd/cmd_en/addr/wr_data/data_mask → rd_data/rd_data_valid/init_calib). It stands in for the PSRAM controller so the RAM bridge runs unchanged on boards without PSRAM and in simulation. The block presents the same burst-of-4 32-bit-beat protocol and a fixed read latency, and stores data in an inferred dual-port BRAM.

---
 rtl/psram_bram_responder_if.sv | 37 +++
 rtl/psram_bram_responder.sv | 192 +++++++++++++++++++
 tb/tb_psram_bram_responder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_bram_responder_if.sv
// User-side command port of the PSRAM controller, as seen by the RAM bridge.
// The master modport is the bridge side, the slave modport is the responder.
// Optional macro PSRAM_BRAM_CMD_CHECK_EN adds the sticky cmd_err flag.
interface psram_bram_responder_if;
  logic        cmd;
  logic        cmd_en;
  logic [20:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  data_mask;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        init_calib;

`ifdef PSRAM_BRAM_CMD_CHECK_EN
  logic        cmd_err;

  modport master (
    output cmd, cmd_en, addr, wr_data, data_mask,
    input  rd_data, rd_data_valid, init_calib, cmd_err
  );

  modport slave (
    input  cmd, cmd_en, addr, wr_data, data_mask,
    output rd_data, rd_data_valid, init_calib, cmd_err
  );
`else
  modport master (
    output cmd, cmd_en, addr, wr_data, data_mask,
    input  rd_data, rd_data_valid, init_calib
  );

  modport slave (
    input  cmd, cmd_en, addr, wr_data, data_mask,
    output rd_data, rd_data_valid, init_calib
  );
`endif
endinterface

// File: rtl/psram_bram_responder.sv
// Block-RAM-backed stand-in for the PSRAM controller user port.
// Bursts of BURST 32-bit beats, fixed read latency READ_LAT, byte masks,
// calibration delay after reset. Memory is never cleared by reset.
// Optional macro PSRAM_BRAM_CMD_CHECK_EN: sticky cmd_err on any ignored cmd_en.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_CALIB    | counting CALIB_CYCLES after reset, commands ignored
// ST_IDLE     | ready; a cmd_en is accepted (write beat 0 stored now)
// ST_WR       | storing write beats 1..BURST-1, one per cycle
// ST_RD_WAIT  | read latency running, BRAM reads start near the end
// ST_RD_BURST | rd_data_valid high, one beat per cycle
module psram_bram_responder #(
  parameter int DEPTH_LOG2   = 12,
  parameter int BURST        = 4,
  parameter int READ_LAT     = 6,
  parameter int CALIB_CYCLES = 64
) (
  input  logic                    clk_out,
  input  logic                    rst_n,
  psram_bram_responder_if.slave   bus
);

  localparam logic [2:0] ST_CALIB    = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_WR       = 3'd2;
  localparam logic [2:0] ST_RD_WAIT  = 3'd3;
  localparam logic [2:0] ST_RD_BURST = 3'd4;

  localparam int AW      = DEPTH_LOG2;
  localparam int TMR_MAX = (CALIB_CYCLES > READ_LAT + BURST) ? CALIB_CYCLES : READ_LAT + BURST;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // One shared down-counter: calibration, write beats left, read timeline.
  localparam logic [TMR_W-1:0] CALIB_LOAD = TMR_W'(CALIB_CYCLES - 1);
  localparam logic [TMR_W-1:0] WR_LOAD    = TMR_W'(BURST - 2);
  localparam logic [TMR_W-1:0] RD_LOAD    = TMR_W'(READ_LAT + BURST - 2);
  // Read timer values: BRAM reads are issued while the timer is in
  // [2, BURST+1]; two register stages later each beat reaches rd_data.
  localparam logic [TMR_W-1:0] ISS_HI     = TMR_W'(BURST + 1);
  localparam logic [TMR_W-1:0] ISS_LO     = TMR_W'(2);
  localparam logic [TMR_W-1:0] TMR_BURST  = TMR_W'(BURST);

  logic [31:0]      mem [0:(1 << DEPTH_LOG2) - 1];

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [AW-1:0]    raddr_q, raddr_d;
  logic             init_calib_q, init_calib_d;
  logic             rd_pend_q;
  logic             rd_valid_q;
  logic [31:0]      rd_data_q;
  logic [31:0]      mem_rdata_q;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [3:0]       mem_be;
  logic             rd_en;

  // Address bits above DEPTH_LOG2 alias the same storage.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[20:AW];

  assign mem_be = ~bus.data_mask;

  // Next-state, timer and memory-port control.
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    waddr_d      = waddr_q;
    raddr_d      = raddr_q;
    init_calib_d = init_calib_q;
    mem_we       = 1'b0;
    mem_waddr    = waddr_q;
    rd_en        = 1'b0;
    case (state_q)
      ST_CALIB: begin
        if (tmr_q == '0) begin
          state_d      = ST_IDLE;
          init_calib_d = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.cmd_en) begin
          if (bus.cmd) begin
            mem_we    = 1'b1;
            mem_waddr = bus.addr[AW-1:0];
            waddr_d   = bus.addr[AW-1:0] + AW'(1);
            tmr_d     = WR_LOAD;
            state_d   = ST_WR;
          end else begin
            raddr_d = bus.addr[AW-1:0];
            tmr_d   = RD_LOAD;
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_WR: begin
        mem_we  = 1'b1;
        waddr_d = waddr_q + AW'(1);
        if (tmr_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_RD_WAIT, ST_RD_BURST: begin
        rd_en = (tmr_q >= ISS_LO) && (tmr_q <= ISS_HI);
        if (rd_en) begin
          raddr_d = raddr_q + AW'(1);
        end
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end
        if (state_q == ST_RD_WAIT && tmr_q == TMR_BURST) begin
          state_d = ST_RD_BURST;
        end else if (state_q == ST_RD_BURST && tmr_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_CALIB;
      end
    endcase
  end

  // Control registers; reset returns to calibration.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CALIB;
      tmr_q        <= CALIB_LOAD;
      waddr_q      <= '0;
      raddr_q      <= '0;
      init_calib_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      waddr_q      <= waddr_d;
      raddr_q      <= raddr_d;
      init_calib_q <= init_calib_d;
      rd_pend_q    <= rd_en;
      rd_valid_q   <= rd_pend_q;
      if (rd_pend_q) begin
        rd_data_q <= mem_rdata_q;
      end
    end
  end

  // Dual-port BRAM with byte enables; no reset so contents survive rst_n.
  always_ff @(posedge clk_out) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem[mem_waddr][8*b +: 8] <= bus.wr_data[8*b +: 8];
        end
      end
    end
    if (rd_en) begin
      mem_rdata_q <= mem[raddr_q];
    end
  end

  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_valid_q;
  assign bus.init_calib    = init_calib_q;

`ifdef PSRAM_BRAM_CMD_CHECK_EN
  logic cmd_err_q;
  logic cmd_ign;

  // Anything but IDLE (calibrating or busy) drops the command.
  assign cmd_ign = bus.cmd_en && (state_q != ST_IDLE);

  // Sticky protocol-violation flag, cleared only by reset.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      cmd_err_q <= 1'b0;
    end else if (cmd_ign) begin
      cmd_err_q <= 1'b1;
    end
  end

  assign bus.cmd_err = cmd_err_q;
`endif

endmodule

// File: tb/tb_psram_bram_responder.sv
// Self-checking bench for psram_bram_responder: a vector table of bursts
// with hand-derived read data, a timed read scoreboard, and hand-written
// sequences for calibration, busy rejection and reset in mid-write.
module tb_psram_bram_responder;
  localparam int READ_LAT = 6;
  localparam int BURST    = 4;
  localparam int NVEC     = 10;

  logic clk_out = 1'b0;
  logic rst_n   = 1'b1;
  always #5 clk_out = ~clk_out;

  psram_bram_responder_if bus_if();

  psram_bram_responder #(
    .DEPTH_LOG2(12), .BURST(BURST), .READ_LAT(READ_LAT), .CALIB_CYCLES(64)
  ) dut (
    .clk_out(clk_out),
    .rst_n  (rst_n),
    .bus    (bus_if)
  );

  typedef struct packed {
    logic             is_wr;
    logic [20:0]      addr;
    logic [3:0][31:0] data;
    logic [3:0][3:0]  mask;
    logic [3:0][31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] cyc;
  } sb_t;

  vec_t vecs [NVEC];
  sb_t  sb_q [$];
  sb_t  sb_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk_out) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [20:0] a, input logic [127:0] d,
                              input logic [15:0] m, input logic [127:0] e);
    vec_t v;
    v.is_wr = wr;
    v.addr  = a;
    v.data  = d;
    v.mask  = m;
    v.exp   = e;
    return v;
  endfunction

  // Every valid beat must match the oldest expected beat, on its cycle.
  always @(negedge clk_out) begin
    if (bus_if.rd_data_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_extra: got beat %h at cyc %0d, want no beat", bus_if.rd_data, cyc);
      end else begin
        sb_e = sb_q.pop_front();
        checks++;
        if (bus_if.rd_data !== sb_e.data || cyc != int'(sb_e.cyc)) begin
          failures++;
          $display("FAIL rd_beat: got %h at cyc %0d, want %h at cyc %0d",
                   bus_if.rd_data, cyc, sb_e.data, sb_e.cyc);
        end
      end
    end
  end

  task automatic push_read(input int c, input logic [3:0][31:0] e);
    sb_t s;
    for (int k = 0; k < BURST; k++) begin
      s.data = e[k];
      s.cyc  = 32'(c + READ_LAT + k);
      sb_q.push_back(s);
    end
  endtask

  // Called at the negedge where a command may be driven; returns at the
  // negedge where the next command is first accepted.
  task automatic do_cmd(input vec_t v);
    int c;
    c = cyc;
    bus_if.cmd_en    = 1'b1;
    bus_if.cmd       = v.is_wr;
    bus_if.addr      = v.addr;
    bus_if.wr_data   = v.data[0];
    bus_if.data_mask = v.mask[0];
    if (v.is_wr) begin
      for (int k = 1; k < BURST; k++) begin
        @(negedge clk_out);
        bus_if.cmd_en    = 1'b0;
        bus_if.wr_data   = v.data[k];
        bus_if.data_mask = v.mask[k];
      end
      @(negedge clk_out);
    end else begin
      push_read(c, v.exp);
      @(negedge clk_out);
      bus_if.cmd_en = 1'b0;
      repeat (READ_LAT + BURST - 1) @(negedge clk_out);
    end
    bus_if.wr_data   = '0;
    bus_if.data_mask = '0;
  endtask

  initial begin
    int   rise;
    logic bad;
    bus_if.cmd       = 1'b0;
    bus_if.cmd_en    = 1'b0;
    bus_if.addr      = '0;
    bus_if.wr_data   = '0;
    bus_if.data_mask = '0;

    // Beat lists are written beat 3 first (index 0 is the low word).
    vecs[0] = mk(1'b1, 21'h10, {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0}, 16'h0000, '0);
    vecs[1] = mk(1'b0, 21'h10, '0, 16'h0000, {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0});
    vecs[2] = mk(1'b1, 21'h20, {32'hDDEEFF00, 32'h99AABBCC, 32'h55667788, 32'h11223344}, 16'h0000, '0);
    vecs[3] = mk(1'b1, 21'h20, {32'h03030303, 32'h02020202, 32'h01010101, 32'hAABBCCDD}, 16'hFFF3, '0);
    vecs[4] = mk(1'b0, 21'h20, '0, 16'h0000, {32'hDDEEFF00, 32'h99AABBCC, 32'h55667788, 32'hAABB3344});
    vecs[5] = mk(1'b1, 21'hFFE, {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0}, 16'h0000, '0);
    vecs[6] = mk(1'b0, 21'hFFE, '0, 16'h0000, {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0});
    vecs[7] = mk(1'b1, 21'h002, {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0}, 16'h0000, '0);
    vecs[8] = mk(1'b0, 21'h1000, '0, 16'h0000, {32'hE1E1E1E1, 32'hE0E0E0E0, 32'hC3C3C3C3, 32'hC2C2C2C2});
    vecs[9] = mk(1'b1, 21'h040, {32'h43434343, 32'h42424242, 32'h41414141, 32'h40404040}, 16'h0000, '0);

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk_out);
    check("rst_rd_data", bus_if.rd_data, 32'h0);
    check("rst_rd_valid", 32'(bus_if.rd_data_valid), 32'h0);
    check("rst_init_calib", 32'(bus_if.init_calib), 32'h0);
`ifdef PSRAM_BRAM_CMD_CHECK_EN
    check("rst_cmd_err", 32'(bus_if.cmd_err), 32'h0);
`endif

    // Calibration: j-th negedge after release shows the value at cycle j.
    rst_n = 1'b1;
    rise  = 0;
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk_out);
      if (j == 10) begin
        bus_if.cmd_en = 1'b1;
        bus_if.cmd    = 1'b0;
        bus_if.addr   = 21'h10;
`ifdef PSRAM_BRAM_CMD_CHECK_EN
        check("cmd_err_pre", 32'(bus_if.cmd_err), 32'h0);
`endif
      end
      if (j == 11) begin
        bus_if.cmd_en = 1'b0;
`ifdef PSRAM_BRAM_CMD_CHECK_EN
        check("cmd_err_calib", 32'(bus_if.cmd_err), 32'h1);
`endif
      end
      if (j == 63) check("calib_c63", 32'(bus_if.init_calib), 32'h0);
      if (bus_if.init_calib === 1'b1) begin
        rise = j;
        break;
      end
    end
    check("calib_rise", 32'(rise), 32'd64);

    // Back-to-back table, first command on the first IDLE cycle.
    for (int i = 0; i < NVEC; i++) begin
      do_cmd(vecs[i]);
    end

    // Busy rejection: write cmd_en three cycles into a read.
    begin
      int c;
      c = cyc;
      bus_if.cmd_en = 1'b1;
      bus_if.cmd    = 1'b0;
      bus_if.addr   = 21'h10;
      push_read(c, vecs[1].exp);
      @(negedge clk_out);
      bus_if.cmd_en = 1'b0;
      repeat (2) @(negedge clk_out);
      bus_if.cmd_en  = 1'b1;
      bus_if.cmd     = 1'b1;
      bus_if.addr    = 21'h10;
      bus_if.wr_data = 32'hFFFFFFFF;
      @(negedge clk_out);
      bus_if.cmd_en  = 1'b0;
`ifdef PSRAM_BRAM_CMD_CHECK_EN
      check("cmd_err_busy", 32'(bus_if.cmd_err), 32'h1);
`endif
      repeat (READ_LAT + BURST - 4) @(negedge clk_out);
    end
    do_cmd(vecs[1]);
    check("rd_hold_data", bus_if.rd_data, 32'hA3A3A3A3);
    check("rd_hold_valid", 32'(bus_if.rd_data_valid), 32'h0);

    // Reset after write beat 1 at 0x40.
    bus_if.cmd_en    = 1'b1;
    bus_if.cmd       = 1'b1;
    bus_if.addr      = 21'h40;
    bus_if.wr_data   = 32'h50505050;
    bus_if.data_mask = 4'h0;
    @(negedge clk_out);
    bus_if.cmd_en  = 1'b0;
    bus_if.wr_data = 32'h51515151;
    @(negedge clk_out);
    rst_n          = 1'b0;
    bus_if.wr_data = 32'h52525252;
    bad = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk_out);
      if (bus_if.rd_data_valid !== 1'b0) bad = 1'b1;
    end
    check("rst_valid_low", 32'(bad), 32'h0);
    check("rst2_rd_data", bus_if.rd_data, 32'h0);
    check("rst2_init_calib", 32'(bus_if.init_calib), 32'h0);
`ifdef PSRAM_BRAM_CMD_CHECK_EN
    check("rst2_cmd_err", 32'(bus_if.cmd_err), 32'h0);
`endif
    bus_if.wr_data = '0;
    rst_n = 1'b1;
    rise  = 0;
    for (int j = 1; j <= 200; j++) begin
      @(negedge clk_out);
      if (bus_if.init_calib === 1'b1) begin
        rise = j;
        break;
      end
    end
    check("recalib_rise", 32'(rise), 32'd64);
    do_cmd(mk(1'b0, 21'h40, '0, 16'h0000,
              {32'h43434343, 32'h42424242, 32'h51515151, 32'h50505050}));

    repeat (20) @(negedge clk_out);
    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
